// File: rtl/sargantana_icache_refill_writer.sv
// Refill writer for the I-cache way SRAMs: takes one miss, gathers the refill
// line from fixed-width beats, then writes the assembled set word into the
// victim way. Fetch reads share the SRAM port and win over the pending write
// for at most MAX_STALL consecutive cycles.
module sargantana_icache_refill_writer #(
  parameter int SET_WIDHT  = 256,
  parameter int ADDR_WIDHT = 6,
  parameter int BEAT_WIDTH = 64,
  parameter int NUM_WAYS   = 4,
  parameter int MAX_STALL  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  miss_valid_i,
  output logic                  miss_ready_o,
  input  logic [ADDR_WIDHT-1:0] miss_idx_i,
  input  logic [NUM_WAYS-1:0]   miss_way_i,
  input  logic                  beat_valid_i,
  output logic                  beat_ready_o,
  input  logic [BEAT_WIDTH-1:0] beat_data_i,
  input  logic                  beat_err_i,
  input  logic                  rd_req_i,
  input  logic [ADDR_WIDHT-1:0] rd_idx_i,
  output logic                  rd_gnt_o,
  output logic [NUM_WAYS-1:0]   way_req_o,
  output logic                  way_we_o,
  output logic [ADDR_WIDHT-1:0] way_addr_o,
  output logic [SET_WIDHT-1:0]  way_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int NBEATS  = SET_WIDHT / BEAT_WIDTH;
  localparam int CNT_W   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int STALL_W = $clog2(MAX_STALL + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [STALL_W-1:0]    r_stall;
  logic                  r_err_flag;
  logic                  r_err_pulse;
  logic [ADDR_WIDHT-1:0] r_idx;
  logic [NUM_WAYS-1:0]   r_way;
  logic [SET_WIDHT-1:0]  r_buf;

  logic w_miss_hs;
  logic w_beat_hs;
  logic w_last_beat;
  logic w_err_now;
  logic w_stall;
  logic w_issue;

  // Handshake qualifiers and the write-versus-read arbitration decision.
  always_comb begin
    w_miss_hs   = miss_valid_i && (r_state == ST_IDLE);
    w_beat_hs   = beat_valid_i && (r_state == ST_FILL);
    w_last_beat = (r_cnt == CNT_W'(NBEATS - 1));
    w_err_now   = r_err_flag | beat_err_i;
    w_stall     = rd_req_i && (r_stall < STALL_W'(MAX_STALL));
    w_issue     = (r_state == ST_WRITE) && !w_stall;
  end

  // Control state: FSM register, beat counter, stall counter, error tracking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_stall     <= '0;
      r_err_flag  <= 1'b0;
      r_err_pulse <= 1'b0;
    end else begin
      // NOTE: all sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      r_state     <= w_state_next;
      r_err_pulse <= w_beat_hs && w_last_beat && w_err_now;
      if (w_miss_hs) begin
        r_cnt      <= '0;
        r_err_flag <= 1'b0;
      end else if (w_beat_hs) begin
        r_cnt      <= r_cnt + CNT_W'(1);
        r_err_flag <= w_err_now;
      end
      if (w_issue) begin
        r_stall <= '0;
      end else if ((r_state == ST_WRITE) && w_stall) begin
        r_stall <= r_stall + STALL_W'(1);
      end
    end
  end

  // Miss capture and line assembly; beat k lands at bits [k*BEAT_WIDTH +: BEAT_WIDTH].
  // NOTE: this datapath is deliberately left without reset: it is only consumed
  // after a miss has overwritten it, so a reset would just cost routing.
  always_ff @(posedge clk_i) begin
    if (w_miss_hs) begin
      r_idx <= miss_idx_i;
      r_way <= miss_way_i;
    end
    if (w_beat_hs) begin
      r_buf[r_cnt*BEAT_WIDTH +: BEAT_WIDTH] <= beat_data_i;
    end
  end

  // Next-state and output decode; the SRAM port follows the fetch read unless the write issues.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    w_state_next = r_state;
    miss_ready_o = 1'b0;
    beat_ready_o = 1'b0;
    rd_gnt_o     = rd_req_i;
    way_req_o    = {NUM_WAYS{rd_req_i}};
    way_we_o     = 1'b0;
    way_addr_o   = rd_idx_i;
    way_data_o   = r_buf;
    busy_o       = (r_state != ST_IDLE);
    done_o       = 1'b0;
    err_o        = r_err_pulse;

    case (r_state)
      ST_IDLE: begin
        miss_ready_o = 1'b1;
        if (miss_valid_i) w_state_next = ST_FILL;
      end
      ST_FILL: begin
        beat_ready_o = 1'b1;
        if (w_beat_hs && w_last_beat) begin
          w_state_next = w_err_now ? ST_IDLE : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (w_issue) begin
          rd_gnt_o     = 1'b0;
          way_req_o    = r_way;
          way_we_o     = 1'b1;
          way_addr_o   = r_idx;
          done_o       = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

endmodule
